// File: rtl/serial_sequence_generator_pkg.sv
// Shared types and default sizing for the serial sequence generator.
package seq_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEF_W  = 8;
    localparam int DEF_RW = 4;

endpackage

// File: rtl/serial_sequence_generator_if.sv
// Request/serial-output bundle between a sequence requester and the generator.
interface serial_sequence_generator_if
    import seq_gen_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int RW = DEF_RW
);
    localparam int LW = $clog2(W);

    logic          start;
    logic [W-1:0]  pattern;
    logic [LW-1:0] len_m1;
    logic [RW-1:0] reps_m1;
    logic          abort;
    logic          ready;
    logic          a;
    logic          a_valid;
    logic          last;

    modport master (
        output start, pattern, len_m1, reps_m1, abort,
        input  ready, a, a_valid, last
    );

    modport slave (
        input  start, pattern, len_m1, reps_m1, abort,
        output ready, a, a_valid, last
    );
endinterface

// File: rtl/serial_sequence_generator.sv
// Serialises a captured pattern MSB-first (from len_m1 down to 0), repeated
// reps_m1+1 times back-to-back, with registered a/a_valid/last.
module serial_sequence_generator
    import seq_gen_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int RW = DEF_RW
) (
    input logic                       clk,
    input logic                       rst,
    serial_sequence_generator_if.slave bus
);
    localparam int LW = $clog2(W);

    state_t        state;
    logic [W-1:0]  pat_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [RW-1:0] reps_q;
    logic [LW-1:0] idx_dn;

    assign bus.ready = (state == IDLE);
    assign idx_dn    = idx_q - LW'(1);

    // idx_q is the index of the bit currently on a; reps_q counts repetitions still owed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            reps_q      <= '0;
            bus.a       <= 1'b0;
            bus.a_valid <= 1'b0;
            bus.last    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.a       <= 1'b0;
                    bus.a_valid <= 1'b0;
                    bus.last    <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        state       <= SEND;
                        pat_q       <= bus.pattern;
                        len_q       <= bus.len_m1;
                        reps_q      <= bus.reps_m1;
                        idx_q       <= bus.len_m1;
                        bus.a       <= bus.pattern[bus.len_m1];
                        bus.a_valid <= 1'b1;
                        bus.last    <= (bus.len_m1 == '0) && (bus.reps_m1 == '0);
                    end
                end
                SEND: begin
                    if (bus.abort || ((idx_q == '0) && (reps_q == '0))) begin
                        state       <= IDLE;
                        bus.a       <= 1'b0;
                        bus.a_valid <= 1'b0;
                        bus.last    <= 1'b0;
                    end else if (idx_q == '0) begin
                        reps_q   <= reps_q - RW'(1);
                        idx_q    <= len_q;
                        bus.a    <= pat_q[len_q];
                        bus.last <= (len_q == '0) && (reps_q == RW'(1));
                    end else begin
                        idx_q    <= idx_dn;
                        bus.a    <= pat_q[idx_dn];
                        bus.last <= (idx_dn == '0) && (reps_q == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sequence_generator.sv
// Directed scoreboard bench for serial_sequence_generator.
module tb_serial_sequence_generator;
    import seq_gen_pkg::*;

    localparam int W  = 8;
    localparam int RW = 4;
    localparam int LW = $clog2(W);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_sequence_generator_if #(.W(W), .RW(RW)) bus ();
    serial_sequence_generator #(.W(W), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic a;
        logic last;
    } exp_t;

    exp_t        sb[$];
    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned nvalid, nlast, bitpos;
    logic [5:0]  hist;
    logic [31:0] hit110011, hit1010;
    logic        prev_last, cur_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_tx();
        nvalid = 0; nlast = 0; bitpos = 0; hist = '0;
        hit110011 = '0; hit1010 = '0;
    endtask

    // One clock; scoreboard pops an expected bit for every a_valid cycle.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        prev_last = cur_last;
        cur_last  = bus.last;
        if (bus.a_valid === 1'b1) begin
            nvalid++;
            if (bus.last === 1'b1) nlast++;
            hist = {hist[4:0], bus.a};
            bitpos++;
            if (bitpos >= 6 && hist == 6'b110011) hit110011[bitpos-1] = 1'b1;
            if (bitpos >= 4 && hist[3:0] == 4'b1010) hit1010[bitpos-1] = 1'b1;
            if (sb.size() == 0) begin
                check("unexpected_bit", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("a", {31'd0, bus.a}, {31'd0, e.a});
                check("last", {31'd0, bus.last}, {31'd0, e.last});
            end
        end else begin
            check("idle_a_last", {30'd0, bus.a, bus.last}, 32'd0);
        end
    endtask

    task automatic send(input logic [W-1:0] p, input logic [LW-1:0] l, input logic [RW-1:0] r);
        exp_t e;
        bus.pattern = p;
        bus.len_m1  = l;
        bus.reps_m1 = r;
        bus.start   = 1'b1;
        for (int k = 0; k <= int'(r); k++) begin
            for (int i = int'(l); i >= 0; i--) begin
                e.a    = p[i];
                e.last = (k == int'(r)) && (i == 0);
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input string tag, input int unsigned exp_valid, input int unsigned exp_last);
        for (int n = 0; n < 200; n++) begin
            tick();
            if (bus.ready === 1'b1) break;
        end
        check({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
        check({tag, "_ready_after_last"}, {31'd0, prev_last}, 32'd1);
        check({tag, "_drained"}, sb.size(), 32'd0);
        check({tag, "_nvalid"}, nvalid, exp_valid);
        check({tag, "_nlast"}, nlast, exp_last);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.pattern = '0; bus.len_m1 = '0; bus.reps_m1 = '0;
        prev_last = 1'b0; cur_last = 1'b0;
        begin_tx();

        // Reset state
        tick();
        tick();
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_valid", {31'd0, bus.a_valid}, 32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, bus.ready}, 32'd1);

        // 110011 once, latency 1
        begin_tx();
        send(8'h33, 3'd5, 4'd0);
        tick();
        check("latency1_valid", {31'd0, bus.a_valid}, 32'd1);
        check("busy_ready", {31'd0, bus.ready}, 32'd0);
        bus.start = 1'b0;
        wait_done("p33", 6, 1);
        check("det110011", hit110011, 32'h0000_0020);

        // 1010 repeated three times
        begin_tx();
        send(8'h0A, 3'd3, 4'd2);
        tick();
        bus.start = 1'b0;
        wait_done("p0a", 12, 1);
        check("det1010", hit1010, 32'h0000_0AA8);

        // start held high, inputs changed mid-send
        begin_tx();
        send(8'h2D, 3'd5, 4'd0);
        tick();
        send(8'hC5, 3'd2, 4'd0);
        for (int n = 0; n < 20 && nlast == 0; n++) tick();
        check("hold_first_last", nlast, 32'd1);
        check("hold_first_nvalid", nvalid, 32'd6);
        tick();
        check("hold_gap_ready", {31'd0, bus.ready}, 32'd1);
        check("hold_gap_valid", {31'd0, bus.a_valid}, 32'd0);
        tick();
        check("hold_second_valid", {31'd0, bus.a_valid}, 32'd1);
        bus.start = 1'b0;
        wait_done("hold", 9, 2);

        // abort at 3rd bit
        begin_tx();
        send(8'hB6, 3'd7, 4'd1);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.abort = 1'b1;
        sb.delete();
        tick();
        check("abort_valid", {31'd0, bus.a_valid}, 32'd0);
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        check("abort_nlast", nlast, 32'd0);
        check("abort_nvalid", nvalid, 32'd3);
        bus.start = 1'b1;
        tick();
        tick();
        check("abort_start_ignored", {30'd0, bus.ready, bus.a_valid}, 32'd2);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();

        // reset at 4th bit
        begin_tx();
        send(8'h5A, 3'd7, 4'd0);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
        check("midrst_outs", {29'd0, bus.a, bus.a_valid, bus.last}, 32'd0);
        check("midrst_ready", {31'd0, bus.ready}, 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_release_ready", {31'd0, bus.ready}, 32'd1);
        check("midrst_nlast", nlast, 32'd0);

        // max repeats, single bit
        begin_tx();
        send(8'h01, 3'd0, 4'd15);
        tick();
        bus.start = 1'b0;
        wait_done("reps16", 16, 1);

        // single bit, single rep
        begin_tx();
        send(8'h01, 3'd0, 4'd0);
        tick();
        check("single_last", {31'd0, bus.last}, 32'd1);
        bus.start = 1'b0;
        wait_done("single", 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
